// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
//
// Holds the default geometry, the derived address-split widths, the refill
// state encoding and a struct view of a fetch address for that geometry.
// Modules take their geometry as parameters that default to these values.
package icache_pkg;

  localparam int DEF_ADDR_WIDTH  = 64;
  localparam int DEF_INSTR_WIDTH = 32;
  localparam int DEF_SETS        = 16;
  localparam int DEF_LINE_WORDS  = 4;

  // Byte offset within a line, set index and tag widths for the default geometry
  localparam int OFF_BITS = $clog2(DEF_LINE_WORDS) + 2;
  localparam int IDX_BITS = $clog2(DEF_SETS);
  localparam int TAG_BITS = DEF_ADDR_WIDTH - OFF_BITS - IDX_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } icache_state_t;

  // Fetch address split into its cache fields (default geometry)
  typedef struct packed {
    logic [TAG_BITS-1:0] tag;
    logic [IDX_BITS-1:0] index;
    logic [OFF_BITS-3:0] word;
    logic [1:0]          byte_sel;
  } icache_addr_t;

endpackage

// File: rtl/icache_refill_fsm.sv
// Refill controller for the instruction cache.
//
// Tracks the IDLE -> REQ -> FILL sequence for one line refill, owns the beat
// counter, the latched line address and the pending-invalidate flag.
//
// Ports:
//   i_clk, i_arst        clock, asynchronous active-low reset
//   i_miss               fetch is valid and the lookup missed (used in IDLE)
//   i_addr               fetch PC, latched as a line address on a miss
//   i_invalidate         fence.i pulse
//   i_mem_req_ready      memory accepts the refill request
//   i_mem_resp_valid     response beat valid
//   o_idle               controller is in IDLE (lookups allowed)
//   o_mem_req_valid      refill request valid
//   o_line_addr          line-aligned refill address
//   o_beat_we            write the current response beat into the data array
//   o_beat_idx           word slot for the current beat
//   o_fill_done          last beat: write tag and set valid for the line
//   o_clear_all          clear every valid bit at this edge
module icache_refill_fsm
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int OFF_W      = $clog2(DEF_LINE_WORDS) + 2,
  parameter int CNT_W      = $clog2(DEF_LINE_WORDS)
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_miss,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_invalidate,
  input  logic                  i_mem_req_ready,
  input  logic                  i_mem_resp_valid,
  output logic                  o_idle,
  output logic                  o_mem_req_valid,
  output logic [ADDR_WIDTH-1:0] o_line_addr,
  output logic                  o_beat_we,
  output logic [CNT_W-1:0]      o_beat_idx,
  output logic                  o_fill_done,
  output logic                  o_clear_all
);

  icache_state_t         state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] line_q, line_d;
  logic                  pend_inv_q, pend_inv_d;

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      line_q     <= '0;
      pend_inv_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      line_q     <= line_d;
      pend_inv_q <= pend_inv_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_d      = line_q;
    pend_inv_d  = pend_inv_q;
    o_beat_we   = 1'b0;
    o_fill_done = 1'b0;
    o_clear_all = 1'b0;

    case (state_q)
      IDLE: begin
        // An invalidate here takes effect at this edge; lookups this cycle
        // still see the old valid bits.
        o_clear_all = i_invalidate;
        pend_inv_d  = 1'b0;
        if (i_miss) begin
          line_d  = {i_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
          state_d = REQ;
        end
      end

      REQ: begin
        if (i_invalidate) pend_inv_d = 1'b1;
        if (i_mem_req_ready) begin
          cnt_d   = '0;
          state_d = FILL;
        end
      end

      FILL: begin
        if (i_invalidate) pend_inv_d = 1'b1;
        if (i_mem_resp_valid) begin
          o_beat_we = 1'b1;
          if (cnt_q == CNT_W'(LINE_WORDS - 1)) begin
            // A fence.i seen during the refill wipes the new line as well,
            // so the re-lookup misses and refetches.
            o_fill_done = 1'b1;
            o_clear_all = pend_inv_q | i_invalidate;
            pend_inv_d  = 1'b0;
            state_d     = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign o_idle          = (state_q == IDLE);
  assign o_mem_req_valid = (state_q == REQ);
  assign o_line_addr     = line_q;
  assign o_beat_idx      = cnt_q;

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache for the fetch stage.
//
// Looks up the fetch PC combinationally and returns the instruction on a hit.
// On a miss it stalls the pipeline and refills one line from main memory.
//
// Ports:
//   i_clk, i_arst        clock, asynchronous active-low reset
//   i_fetch_en, i_addr   fetch request and byte PC (bits [1:0] ignored)
//   i_invalidate         fence.i pulse, clears all valid bits
//   o_instruction        instruction at i_addr, meaningful only with o_hit
//   o_hit, o_stall       lookup hit, stall request to the hazard unit
//   o_mem_req_*          line refill request (valid/ready)
//   i_mem_resp_*         refill response beats, ascending word order
module instr_cache
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int SETS        = DEF_SETS,
  parameter int LINE_WORDS  = DEF_LINE_WORDS
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_fetch_en,
  input  logic [ADDR_WIDTH-1:0]  i_addr,
  input  logic                   i_invalidate,
  output logic [INSTR_WIDTH-1:0] o_instruction,
  output logic                   o_hit,
  output logic                   o_stall,
  output logic                   o_mem_req_valid,
  output logic [ADDR_WIDTH-1:0]  o_mem_req_addr,
  input  logic                   i_mem_req_ready,
  input  logic                   i_mem_resp_valid,
  input  logic [INSTR_WIDTH-1:0] i_mem_resp_data
);

  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WORD_W + 2;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;

  logic [INSTR_WIDTH-1:0] data_q [SETS][LINE_WORDS];
  logic [TAG_W-1:0]       tag_q  [SETS];
  logic [SETS-1:0]        valid_q, valid_d;

  logic [WORD_W-1:0] lookup_word;
  logic [IDX_W-1:0]  lookup_idx;
  logic [TAG_W-1:0]  lookup_tag;
  logic              lookup_hit;

  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;

  logic              idle;
  logic              beat_we;
  logic [WORD_W-1:0] beat_idx;
  logic              fill_done;
  logic              clear_all;
  logic              unused_addr_bits;

  assign lookup_word = i_addr[OFF_W-1:2];
  assign lookup_idx  = i_addr[OFF_W+IDX_W-1:OFF_W];
  assign lookup_tag  = i_addr[ADDR_WIDTH-1:OFF_W+IDX_W];

  // The refill always targets the latched line, not the live PC
  assign fill_idx = o_mem_req_addr[OFF_W+IDX_W-1:OFF_W];
  assign fill_tag = o_mem_req_addr[ADDR_WIDTH-1:OFF_W+IDX_W];

  assign unused_addr_bits = ^{i_addr[1:0], o_mem_req_addr[OFF_W-1:0]};

  assign lookup_hit    = valid_q[lookup_idx] & (tag_q[lookup_idx] == lookup_tag);
  assign o_hit         = i_fetch_en & idle & lookup_hit;
  assign o_instruction = data_q[lookup_idx][lookup_word];
  assign o_stall       = (i_fetch_en & ~o_hit) | ~idle;

  icache_refill_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LINE_WORDS (LINE_WORDS),
    .OFF_W      (OFF_W),
    .CNT_W      (WORD_W)
  ) u_refill_fsm (
    .i_clk            (i_clk),
    .i_arst           (i_arst),
    .i_miss           (i_fetch_en & ~lookup_hit),
    .i_addr           (i_addr),
    .i_invalidate     (i_invalidate),
    .i_mem_req_ready  (i_mem_req_ready),
    .i_mem_resp_valid (i_mem_resp_valid),
    .o_idle           (idle),
    .o_mem_req_valid  (o_mem_req_valid),
    .o_line_addr      (o_mem_req_addr),
    .o_beat_we        (beat_we),
    .o_beat_idx       (beat_idx),
    .o_fill_done      (fill_done),
    .o_clear_all      (clear_all)
  );

  // Data and tags carry no reset; the valid bits alone make them meaningful
  always_ff @(posedge i_clk) begin
    if (beat_we) data_q[fill_idx][beat_idx] <= i_mem_resp_data;
    if (fill_done) tag_q[fill_idx] <= fill_tag;
  end

  // Clearing wins over setting so an invalidate pending at fill end drops the new line
  always_comb begin
    valid_d = valid_q;
    if (fill_done) valid_d[fill_idx] = 1'b1;
    if (clear_all) valid_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) valid_q <= '0;
    else         valid_q <= valid_d;
  end

endmodule
